// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
//   Shared definitions for the memory port arbiter:
//   - arb_state_t          : arbiter FSM state encoding
//   - DEFAULT_MEM_LATENCY  : default memory read latency in cycles
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_BUSY_IF = 2'd1,
        ARB_BUSY_DM = 2'd2
    } arb_state_t;

    localparam int DEFAULT_MEM_LATENCY = 2;

endpackage

// File: rtl/mem_lat_counter.sv
// mem_lat_counter
//   Loadable down-counter that times the wait between the memory select
//   cycle and the response cycle.
//   Ports:
//     clk   in   clock
//     rstn  in   asynchronous active-low reset (count cleared)
//     load  in   load the count with MEM_LATENCY
//     cnt   out  current count
//     zero  out  count is zero (response cycle while busy)
module mem_lat_counter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LATENCY = DEFAULT_MEM_LATENCY,
    parameter int CW          = $clog2(MEM_LATENCY + 1)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          load,
    output logic [CW-1:0] cnt,
    output logic          zero
);

    localparam logic [CW-1:0] LOAD_VAL = CW'(MEM_LATENCY);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= LOAD_VAL;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port fixed-latency memory between instruction fetch
//   (if_*) and data access (dm_*). One access is outstanding at a time; the
//   data side wins ties because it belongs to the older instruction. A flush
//   cancels an in-flight fetch so its stale word is never delivered.
//   FSM state is held in the internal signal 'state' (arb_state_t).
//   Ports:
//     clk, rstn                 clock, asynchronous active-low reset
//     if_req/if_addr            fetch request, held until if_valid
//     if_rdata/if_valid/if_stall fetch response and stall
//     dm_req/dm_we/dm_addr/dm_wdata/dm_wstrb  data request, held until dm_valid
//     dm_rdata/dm_valid/dm_stall data response and stall
//     flush                     cancels the in-flight fetch / blocks IF grant
//     mem_cs/mem_we/mem_addr/mem_wdata/mem_wstrb  registered memory command
//     mem_rdata                 memory read data, MEM_LATENCY after mem_cs
//   Handshake: a requester raises req with stable payload and holds it until
//   its one-cycle valid pulse; the response cycle is the only cycle valid=1.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int MEM_LATENCY = DEFAULT_MEM_LATENCY
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    if_req,
    input  logic [ADDR_WIDTH-1:0]   if_addr,
    output logic [DATA_WIDTH-1:0]   if_rdata,
    output logic                    if_valid,
    output logic                    if_stall,
    input  logic                    dm_req,
    input  logic                    dm_we,
    input  logic [ADDR_WIDTH-1:0]   dm_addr,
    input  logic [DATA_WIDTH-1:0]   dm_wdata,
    input  logic [DATA_WIDTH/8-1:0] dm_wstrb,
    output logic [DATA_WIDTH-1:0]   dm_rdata,
    output logic                    dm_valid,
    output logic                    dm_stall,
    input  logic                    flush,
    output logic                    mem_cs,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_wstrb,
    input  logic [DATA_WIDTH-1:0]   mem_rdata
);

    localparam int CW = $clog2(MEM_LATENCY + 1);

    arb_state_t    state, state_next;
    logic          grant_if, grant_dm;
    logic          drop;
    logic [CW-1:0] cnt;
    logic          cnt_zero;

    mem_lat_counter #(
        .MEM_LATENCY (MEM_LATENCY),
        .CW          (CW)
    ) u_cnt (
        .clk  (clk),
        .rstn (rstn),
        .load (grant_if | grant_dm),
        .cnt  (cnt),
        .zero (cnt_zero)
    );

    // Next-state and grant decode.
    always_comb begin
        state_next = state;
        grant_if   = 1'b0;
        grant_dm   = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (dm_req) begin
                    grant_dm   = 1'b1;
                    state_next = ARB_BUSY_DM;
                end else if (if_req && !flush) begin
                    // A fetch seen together with flush has a stale address.
                    grant_if   = 1'b1;
                    state_next = ARB_BUSY_IF;
                end
            end
            ARB_BUSY_IF, ARB_BUSY_DM: begin
                if (cnt_zero) state_next = ARB_IDLE;
            end
            default: state_next = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= ARB_IDLE;
            drop      <= 1'b0;
            mem_cs    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
        end else begin
            state  <= state_next;
            mem_cs <= grant_if | grant_dm;
            if (grant_dm) begin
                mem_we    <= dm_we;
                mem_addr  <= dm_addr;
                mem_wdata <= dm_wdata;
                mem_wstrb <= dm_wstrb;
            end else if (grant_if) begin
                mem_we    <= 1'b0;
                mem_addr  <= if_addr;
                mem_wdata <= '0;
                mem_wstrb <= '0;
            end
            // Clearing on the return to IDLE wins over a late flush, so each
            // fetch starts with drop=0.
            if (state_next == ARB_IDLE) begin
                drop <= 1'b0;
            end else if (state == ARB_BUSY_IF && flush) begin
                drop <= 1'b1;
            end
        end
    end

    // A flush in the response cycle itself must also suppress the pulse,
    // hence the direct flush term alongside the registered drop.
    assign if_valid = (state == ARB_BUSY_IF) && cnt_zero && !drop && !flush;
    assign dm_valid = (state == ARB_BUSY_DM) && cnt_zero;
    assign if_rdata = if_valid ? mem_rdata : '0;
    assign dm_rdata = (dm_valid && !mem_we) ? mem_rdata : '0;
    assign if_stall = if_req && !if_valid;
    assign dm_stall = dm_req && !dm_valid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Directed self-checking bench for mem_port_arbiter (MEM_LATENCY=2).
//   Cycle k is the interval after rising edge k; inputs are driven 1 ns
//   after the edge and outputs are checked on the falling edge.
module tb_mem_port_arbiter;

    localparam int DW = 32;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic [DW-1:0] if_rdata;
    logic          if_valid;
    logic          if_stall;
    logic          dm_req = 1'b0;
    logic          dm_we = 1'b0;
    logic [AW-1:0] dm_addr = '0;
    logic [DW-1:0] dm_wdata = '0;
    logic [3:0]    dm_wstrb = '0;
    logic [DW-1:0] dm_rdata;
    logic          dm_valid;
    logic          dm_stall;
    logic          flush = 1'b0;
    logic          mem_cs;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [3:0]    mem_wstrb;
    logic [DW-1:0] mem_rdata = '0;

    int checks   = 0;
    int failures = 0;

    // clock / reset block
    always #5 clk = ~clk;

    mem_port_arbiter #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .MEM_LATENCY (2)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_valid  (if_valid),
        .if_stall  (if_stall),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_wstrb  (dm_wstrb),
        .dm_rdata  (dm_rdata),
        .dm_valid  (dm_valid),
        .dm_stall  (dm_stall),
        .flush     (flush),
        .mem_cs    (mem_cs),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_rdata (mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Start of next cycle (drive point).
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Check point inside the current cycle.
    task automatic sample();
        @(negedge clk);
    endtask

    task automatic idle_outputs(input string tag);
        chk({tag, "_cs"}, mem_cs, 1'b0);
        chk({tag, "_ifv"}, if_valid, 1'b0);
        chk({tag, "_dmv"}, dm_valid, 1'b0);
    endtask

    initial begin
        // ---- reset state ----
        #2;
        chk("rst_cs", mem_cs, 1'b0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_ifstall", if_stall, 1'b0);
        chk("rst_dmrdata", dm_rdata, 32'h0);
        next_cycle();
        rstn = 1'b1;
        next_cycle();

        // ---- fetch ----
        if_req = 1'b1; if_addr = 32'h100;              // cycle 0
        sample(); chk("f_c0_cs", mem_cs, 1'b0); chk("f_c0_stall", if_stall, 1'b1);
        next_cycle();                                   // cycle 1
        sample(); chk("f_c1_cs", mem_cs, 1'b1); chk("f_c1_addr", mem_addr, 32'h100);
        chk("f_c1_we", mem_we, 1'b0); chk("f_c1_stall", if_stall, 1'b1);
        next_cycle();                                   // cycle 2
        sample(); chk("f_c2_cs", mem_cs, 1'b0); chk("f_c2_v", if_valid, 1'b0);
        chk("f_c2_stall", if_stall, 1'b1);
        next_cycle(); mem_rdata = 32'hDEADBEEF;         // cycle 3
        sample(); chk("f_c3_v", if_valid, 1'b1); chk("f_c3_rdata", if_rdata, 32'hDEADBEEF);
        chk("f_c3_stall", if_stall, 1'b0);
        next_cycle(); if_req = 1'b0; mem_rdata = '0;    // cycle 4
        sample(); idle_outputs("f_c4");
        next_cycle();

        // ---- contention: DM wins ----
        if_req = 1'b1; if_addr = 32'h100;               // cycle 0
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h2000;
        sample(); chk("c_c0_ifstall", if_stall, 1'b1); chk("c_c0_dmstall", dm_stall, 1'b1);
        next_cycle();                                   // cycle 1
        sample(); chk("c_c1_cs", mem_cs, 1'b1); chk("c_c1_addr", mem_addr, 32'h2000);
        next_cycle();                                   // cycle 2
        next_cycle(); mem_rdata = 32'hCAFEF00D;         // cycle 3
        sample(); chk("c_c3_dmv", dm_valid, 1'b1); chk("c_c3_dmrd", dm_rdata, 32'hCAFEF00D);
        chk("c_c3_ifv", if_valid, 1'b0); chk("c_c3_ifstall", if_stall, 1'b1);
        chk("c_c3_dmstall", dm_stall, 1'b0);
        next_cycle(); dm_req = 1'b0; mem_rdata = '0;    // cycle 4
        sample(); chk("c_c4_cs", mem_cs, 1'b0); chk("c_c4_ifstall", if_stall, 1'b1);
        next_cycle();                                   // cycle 5
        sample(); chk("c_c5_cs", mem_cs, 1'b1); chk("c_c5_addr", mem_addr, 32'h100);
        next_cycle();                                   // cycle 6
        sample(); chk("c_c6_ifstall", if_stall, 1'b1); chk("c_c6_ifv", if_valid, 1'b0);
        next_cycle(); mem_rdata = 32'h11112222;         // cycle 7
        sample(); chk("c_c7_ifv", if_valid, 1'b1); chk("c_c7_ifrd", if_rdata, 32'h11112222);
        next_cycle(); if_req = 1'b0; mem_rdata = '0;    // cycle 8
        next_cycle();

        // ---- store ----
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h40;  // cycle 0
        dm_wdata = 32'h1234; dm_wstrb = 4'b0011;
        next_cycle();                                   // cycle 1
        sample(); chk("s_c1_cs", mem_cs, 1'b1); chk("s_c1_we", mem_we, 1'b1);
        chk("s_c1_strb", mem_wstrb, 4'b0011); chk("s_c1_wdata", mem_wdata, 32'h1234);
        chk("s_c1_addr", mem_addr, 32'h40);
        next_cycle();                                   // cycle 2
        sample(); chk("s_c2_we_hold", mem_we, 1'b1); chk("s_c2_cs", mem_cs, 1'b0);
        next_cycle(); mem_rdata = 32'hFFFFFFFF;         // cycle 3
        sample(); chk("s_c3_dmv", dm_valid, 1'b1); chk("s_c3_dmrd", dm_rdata, 32'h0);
        chk("s_c3_ifv", if_valid, 1'b0);
        next_cycle(); dm_req = 1'b0; dm_we = 1'b0; mem_rdata = '0; // cycle 4
        next_cycle();

        // ---- flush of an in-flight fetch ----
        if_req = 1'b1; if_addr = 32'h100;               // cycle 0
        next_cycle();                                   // cycle 1
        sample(); chk("fl_c1_we", mem_we, 1'b0); chk("fl_c1_strb", mem_wstrb, 4'b0);
        next_cycle(); flush = 1'b1;                     // cycle 2
        next_cycle(); flush = 1'b0; mem_rdata = 32'h0BAD0BAD; // cycle 3
        sample(); chk("fl_c3_ifv", if_valid, 1'b0); chk("fl_c3_ifrd", if_rdata, 32'h0);
        chk("fl_c3_stall", if_stall, 1'b1);
        next_cycle(); if_addr = 32'h200; mem_rdata = '0; // cycle 4
        sample(); chk("fl_c4_cs", mem_cs, 1'b0); chk("fl_c4_stall", if_stall, 1'b1);
        next_cycle();                                   // cycle 5
        sample(); chk("fl_c5_cs", mem_cs, 1'b1); chk("fl_c5_addr", mem_addr, 32'h200);
        next_cycle();                                   // cycle 6
        next_cycle(); mem_rdata = 32'h55AA55AA;         // cycle 7
        sample(); chk("fl_c7_ifv", if_valid, 1'b1); chk("fl_c7_ifrd", if_rdata, 32'h55AA55AA);
        next_cycle(); if_req = 1'b0; mem_rdata = '0;    // cycle 8
        next_cycle();

        // ---- flush in IDLE ----
        if_req = 1'b1; if_addr = 32'h300; flush = 1'b1; // cycle 0
        next_cycle();                                   // cycle 1
        sample(); chk("fi_c1_cs", mem_cs, 1'b0); chk("fi_c1_stall", if_stall, 1'b1);
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h80;  // still flushing
        next_cycle();                                   // cycle 2
        sample(); chk("fi_c2_cs", mem_cs, 1'b1); chk("fi_c2_addr", mem_addr, 32'h80);
        next_cycle();                                   // cycle 3
        next_cycle(); mem_rdata = 32'h77778888;         // cycle 4
        sample(); chk("fi_c4_dmv", dm_valid, 1'b1); chk("fi_c4_dmrd", dm_rdata, 32'h77778888);
        next_cycle(); dm_req = 1'b0; flush = 1'b0; mem_rdata = '0; // cycle 5
        next_cycle();                                   // cycle 6
        sample(); chk("fi_c6_cs", mem_cs, 1'b1); chk("fi_c6_addr", mem_addr, 32'h300);
        next_cycle();                                   // cycle 7
        next_cycle(); mem_rdata = 32'h9999AAAA;         // cycle 8
        sample(); chk("fi_c8_ifv", if_valid, 1'b1);
        next_cycle(); if_req = 1'b0; mem_rdata = '0;    // cycle 9
        next_cycle();

        // ---- reset mid-access ----
        if_req = 1'b1; if_addr = 32'h400;               // cycle 0
        next_cycle();                                   // cycle 1
        sample(); chk("r_c1_cs", mem_cs, 1'b1);
        dm_req = 1'b1; dm_addr = 32'h500;
        #2; rstn = 1'b0; #1;
        chk("r_async_cs", mem_cs, 1'b0); chk("r_async_addr", mem_addr, 32'h0);
        chk("r_async_ifv", if_valid, 1'b0);
        next_cycle(); if_req = 1'b0; dm_req = 1'b0; mem_rdata = 32'h12345678;
        sample(); chk("r_hold_cs", mem_cs, 1'b0);
        next_cycle(); rstn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sample(); idle_outputs("r_post");
            next_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
